// File: rtl/instr_loader.sv
// Byte-stream program loader: packs 4 bytes per instruction and writes them into
// instruction_memory at consecutive addresses. Optional checksum byte via LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter bit         MSB_FIRST  = 1'b1,
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        loader_reset,
    input  logic        start,
    input  logic [7:0]  num_words,
    input  logic        abort,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        load_memory,
    output logic [7:0]  mem_addr_select,
    output logic [31:0] instr_mem_input,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        chk_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 9;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q;
    logic [CNT_W-1:0]    words_left_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WORD_W-1:0]   asm_q;

    logic                byte_acc_c;
    logic                start_acc_c;
    logic                word_full_c;
    logic                sess_d_c;
    logic                ready_d_c;
    logic [WORD_W-1:0]   asm_next_c;

    // Handshake qualifiers and the word as it will look once this byte is shifted in
    always_comb begin
        byte_acc_c  = byte_valid && byte_ready;
        start_acc_c = start && !abort && ((state_q == IDLE) || (state_q == DONE));
        word_full_c = byte_acc_c && (state_q == RECV) && (byte_cnt_q == 2'd3);
        asm_next_c  = MSB_FIRST ? {asm_q[WORD_W-BYTE_W-1:0], byte_data}
                                : {byte_data, asm_q[WORD_W-1:BYTE_W]};
    end

    // Next-state logic; abort overrides everything, a WRITE already on the bus still completes
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = RECV;
                RECV:       if (word_full_c) state_d = WRITE;
                WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = (words_left_q == CNT_W'(1)) ? CHECK : RECV;
`else
                    state_d = (words_left_q == CNT_W'(1)) ? DONE : RECV;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK:      if (byte_acc_c) state_d = DONE;
`endif
                default:    state_d = IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with state_q
    always_comb begin
        sess_d_c  = (state_d == RECV) || (state_d == WRITE);
        ready_d_c = (state_d == RECV);
`ifdef LOADER_CHECKSUM_EN
        sess_d_c  = sess_d_c || (state_d == CHECK);
        ready_d_c = ready_d_c || (state_d == CHECK);
`endif
    end

    always_ff @(posedge clk or posedge loader_reset) begin
        if (loader_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or posedge loader_reset) begin
        if (loader_reset) begin
            byte_cnt_q      <= '0;
            words_left_q    <= '0;
            addr_q          <= '0;
            asm_q           <= '0;
            byte_ready      <= 1'b0;
            load_memory     <= 1'b0;
            mem_addr_select <= '0;
            instr_mem_input <= '0;
            cpu_hold        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            byte_ready  <= ready_d_c;
            load_memory <= (state_d == WRITE);
            cpu_hold    <= sess_d_c;
            busy        <= sess_d_c;
            done        <= (state_d == DONE);

            if (start_acc_c) begin
                words_left_q <= (num_words == '0) ? CNT_W'(256) : CNT_W'(num_words);
                addr_q       <= START_ADDR;
                byte_cnt_q   <= '0;
            end

            if (byte_acc_c && (state_q == RECV)) begin
                asm_q      <= asm_next_c;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end

            if (word_full_c && !abort) begin
                mem_addr_select <= addr_q;
                instr_mem_input <= asm_next_c;
            end

            if (state_q == WRITE) begin
                addr_q       <= addr_q + ADDR_W'(1);
                words_left_q <= words_left_q - CNT_W'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;

    // Running XOR over the data bytes, compared against the trailing checksum byte
    always_ff @(posedge clk or posedge loader_reset) begin
        if (loader_reset) begin
            xor_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (start_acc_c) begin
                xor_q   <= '0;
                chk_err <= 1'b0;
            end else if (byte_acc_c && (state_q == RECV)) begin
                xor_q <= xor_q ^ byte_data;
            end else if (byte_acc_c && (state_q == CHECK) && !abort) begin
                chk_err <= (byte_data != xor_q);
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: two instances (MSB-first @0x00, LSB-first @0xFF) share one stimulus.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        loader_reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  num_words = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;

    logic        br_m, lm_m, hold_m, busy_m, done_m, ce_m;
    logic [7:0]  addr_m;
    logic [31:0] data_m;
    logic        br_l, lm_l, hold_l, busy_l, done_l, ce_l;
    logic [7:0]  addr_l;
    logic [31:0] data_l;

    int errors = 0;
    int checks = 0;

    logic [39:0] got_m[$];
    logic [39:0] got_l[$];
    logic [7:0]  stim[$];
    int          base_m, base_l;

    always #5 clk = ~clk;

    instr_loader #(.MSB_FIRST(1'b1), .START_ADDR(8'h00)) u_m (
        .clk(clk), .loader_reset(loader_reset), .start(start), .num_words(num_words),
        .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(br_m), .load_memory(lm_m), .mem_addr_select(addr_m),
        .instr_mem_input(data_m), .cpu_hold(hold_m), .busy(busy_m), .done(done_m),
        .chk_err(ce_m)
    );

    instr_loader #(.MSB_FIRST(1'b0), .START_ADDR(8'hFF)) u_l (
        .clk(clk), .loader_reset(loader_reset), .start(start), .num_words(num_words),
        .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(br_l), .load_memory(lm_l), .mem_addr_select(addr_l),
        .instr_mem_input(data_l), .cpu_hold(hold_l), .busy(busy_l), .done(done_l),
        .chk_err(ce_l)
    );

    // Write monitor: every strobe cycle is one memory write
    always @(negedge clk) begin
        if (lm_m) got_m.push_back({addr_m, data_m});
        if (lm_l) got_l.push_back({addr_l, data_l});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: instruction word from four bytes in arrival order
    function automatic logic [31:0] pack_word(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d,
                                              input bit msb);
        return msb ? {a, b, c, d} : {d, c, b, a};
    endfunction

    function automatic logic [7:0] stim_xor();
        logic [7:0] x = '0;
        foreach (stim[i]) x = x ^ stim[i];
        return x;
    endfunction

    task automatic do_start(input logic [7:0] nw);
        @(negedge clk);
        start = 1'b1; num_words = nw;
        byte_valid = 1'b1; byte_data = 8'hA5;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1; byte_data = b;
        while (!br_m && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!br_m) chk("byte_ready_timeout", 64'(br_m), 64'(1));
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!done_m && t < 32) begin
            @(negedge clk);
            t++;
        end
        chk("done_m", 64'(done_m), 64'(1));
        chk("done_l", 64'(done_l), 64'(1));
    endtask

    task automatic check_writes(input int n);
        chk("wr_count_m", 64'(got_m.size() - base_m), 64'(n));
        chk("wr_count_l", 64'(got_l.size() - base_l), 64'(n));
        for (int w = 0; w < n; w++) begin
            logic [39:0] em, el;
            em = {8'(w), pack_word(stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3], 1'b1)};
            el = {8'(255 + w), pack_word(stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3], 1'b0)};
            if (base_m + w < got_m.size()) chk("write_m", 64'(got_m[base_m + w]), 64'(em));
            if (base_l + w < got_l.size()) chk("write_l", 64'(got_l[base_l + w]), 64'(el));
        end
    endtask

    task automatic run_session(input int nfield, input int gap_max, input bit bad_chk,
                               input bit mid_start);
        int n = (nfield == 0) ? 256 : nfield;
        logic exp_ce = 1'b0;
        base_m = got_m.size();
        base_l = got_l.size();
        do_start(8'(nfield));
        for (int i = 0; i < stim.size(); i++) begin
            if (mid_start && i == 2) begin
                @(negedge clk);
                start = 1'b1; num_words = 8'd5;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(stim[i], int'($urandom_range(gap_max, 0)));
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_chk ? (stim_xor() ^ 8'h01) : stim_xor(), 0);
        exp_ce = bad_chk;
`endif
        wait_done();
        chk("hold_after_done", 64'({hold_m, busy_m, hold_l, busy_l}), 64'(0));
        chk("ready_after_done", 64'({br_m, br_l}), 64'(0));
        chk("chk_err", 64'({ce_m, ce_l}), 64'({exp_ce, exp_ce}));
        check_writes(n);
    endtask

    typedef struct {
        logic [31:0] bytes;
        logic [31:0] exp_msb;
        logic [31:0] exp_lsb;
        bit          bad_chk;
        bit          mid_start;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h12345678, 32'h12345678, 32'h78563412, 1'b0, 1'b0};
        vecs[1] = '{32'h78563412, 32'h78563412, 32'h12345678, 1'b0, 1'b1};
        vecs[2] = '{32'h01020304, 32'h01020304, 32'h04030201, 1'b0, 1'b0};
        vecs[3] = '{32'h01020304, 32'h01020304, 32'h04030201, 1'b1, 1'b0};
        vecs[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE, 1'b0, 1'b1};
        vecs[5] = '{32'hFF00FF00, 32'hFF00FF00, 32'h00FF00FF, 1'b1, 1'b0};

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_m", 64'({br_m, lm_m, addr_m, data_m, hold_m, busy_m, done_m, ce_m}), 64'(0));
        chk("reset_l", 64'({br_l, lm_l, addr_l, data_l, hold_l, busy_l, done_l, ce_l}), 64'(0));
        loader_reset = 1'b0;

        // Reset after two bytes: immediate clear, then a clean one-word load
        do_start(8'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        chk("hold_before_reset", 64'(hold_m), 64'(1));
        loader_reset = 1'b1;
        #1;
        chk("midreset_m", 64'({br_m, lm_m, addr_m, data_m, hold_m, busy_m, done_m, ce_m}), 64'(0));
        @(negedge clk);
        loader_reset = 1'b0;
        stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_session(1, 1, 1'b0, 1'b0);

        // Table of single-word loads
        for (int v = 0; v < 6; v++) begin
            logic [31:0] bw;
            bw = vecs[v].bytes;
            stim = '{bw[31:24], bw[23:16], bw[15:8], bw[7:0]};
            run_session(1, 2, vecs[v].bad_chk, vecs[v].mid_start);
            if (got_m.size() > base_m) chk("tbl_m", 64'(got_m[base_m]), 64'({8'h00, vecs[v].exp_msb}));
            if (got_l.size() > base_l) chk("tbl_l", 64'(got_l[base_l]), 64'({8'hFF, vecs[v].exp_lsb}));
        end

        // Two-word load with known values
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_session(2, 0, 1'b0, 1'b0);
        if (got_m.size() >= base_m + 2) begin
            chk("two_m0", 64'(got_m[base_m]),     64'({8'h00, 32'h12345678}));
            chk("two_m1", 64'(got_m[base_m + 1]), 64'({8'h01, 32'h9ABCDEF0}));
        end
        if (got_l.size() >= base_l + 2) begin
            chk("two_l0", 64'(got_l[base_l]),     64'({8'hFF, 32'h78563412}));
            chk("two_l1", 64'(got_l[base_l + 1]), 64'({8'h00, 32'hF0DEBC9A}));
        end

        // num_words=0: full 256-word sweep
        stim.delete();
        for (int i = 0; i < 1024; i++) stim.push_back(8'($urandom));
        run_session(0, 0, 1'b0, 1'b0);

        // Abort after 6th byte of a 3-word load
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        base_m = got_m.size();
        base_l = got_l.size();
        do_start(8'd3);
        foreach (stim[i]) send_byte(stim[i], 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_state", 64'({hold_m, busy_m, done_m, br_m, lm_m}), 64'(0));
        chk("abort_wr_m", 64'(got_m.size() - base_m), 64'(1));
        if (got_m.size() > base_m) chk("abort_data_m", 64'(got_m[base_m]), 64'({8'h00, 32'h01020304}));
        if (got_l.size() > base_l) chk("abort_data_l", 64'(got_l[base_l]), 64'({8'hFF, 32'h04030201}));
        stim = '{8'hC0, 8'hFF, 8'hEE, 8'h01};
        run_session(1, 1, 1'b0, 1'b0);

        // Abort coinciding with the write strobe: that write still lands
        stim = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        base_m = got_m.size();
        do_start(8'd2);
        foreach (stim[i]) send_byte(stim[i], 0);
        abort = 1'b1;
        @(negedge clk);
        chk("abort_strobe", 64'(lm_m), 64'(1));
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_strobe_state", 64'({hold_m, done_m, br_m, lm_m}), 64'(0));
        chk("abort_strobe_wr", 64'(got_m.size() - base_m), 64'(1));
        if (got_m.size() > base_m) chk("abort_strobe_data", 64'(got_m[base_m]), 64'({8'h00, 32'h5A6B7C8D}));

        // Randomized sessions against the reference model
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(5, 1));
            stim.delete();
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            run_session(n, 3, r[0], 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
